// File: rtl/bus_arbiter_if.sv
// Shared-bus bundle between the CPU, the two secondary masters (PRC, DBG) and the arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives the requesters.
interface bus_arbiter_if;
  logic        cpu_bus_ack;
  logic [23:0] cpu_address_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_write;
  logic        cpu_read;
  logic [1:0]  cpu_bus_status;

  logic        prc_req;
  logic [23:0] prc_address_in;
  logic [7:0]  prc_data_in;
  logic        prc_write;
  logic        prc_read;
  logic [1:0]  prc_bus_status;

  logic        dbg_req;
  logic [23:0] dbg_address_in;
  logic [7:0]  dbg_data_in;
  logic        dbg_write;
  logic        dbg_read;
  logic [1:0]  dbg_bus_status;

  logic        cpu_bus_request;
  logic        prc_grant;
  logic        dbg_grant;
  logic [23:0] address_out;
  logic [7:0]  data_out;
  logic        write;
  logic        read;
  logic [1:0]  bus_status;
  logic        timeout_error;

  modport slave (
    input  cpu_bus_ack, cpu_address_in, cpu_data_in, cpu_write, cpu_read, cpu_bus_status,
    input  prc_req, prc_address_in, prc_data_in, prc_write, prc_read, prc_bus_status,
    input  dbg_req, dbg_address_in, dbg_data_in, dbg_write, dbg_read, dbg_bus_status,
    output cpu_bus_request, prc_grant, dbg_grant,
    output address_out, data_out, write, read, bus_status, timeout_error
  );

  modport master (
    output cpu_bus_ack, cpu_address_in, cpu_data_in, cpu_write, cpu_read, cpu_bus_status,
    output prc_req, prc_address_in, prc_data_in, prc_write, prc_read, prc_bus_status,
    output dbg_req, dbg_address_in, dbg_data_in, dbg_write, dbg_read, dbg_bus_status,
    input  cpu_bus_request, prc_grant, dbg_grant,
    input  address_out, data_out, write, read, bus_status, timeout_error
  );
endinterface

// File: rtl/bus_arbiter.sv
// Hands the system bus from the CPU to PRC or DBG (round-robin on ties) after the CPU acks.
// Grant 2 clk_ce cycles after request at best; back-to-back grants pass through one idle GAP cycle.
module bus_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_ce,
  bus_arbiter_if.slave  bus
);

  localparam logic [2:0] CPU_OWN   = 3'd0;
  localparam logic [2:0] WAIT_ACK  = 3'd1;
  localparam logic [2:0] GRANT_PRC = 3'd2;
  localparam logic [2:0] GRANT_DBG = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] RELEASE   = 3'd5;

  localparam logic [1:0] BUS_COMMAND_IDLE = 2'b00;

  logic [2:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        last_prc_q, last_prc_d;
  logic        win_dbg_q, win_dbg_d;   // latched winner, or next owner while in GAP
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic win_req, own_req, oth_req;

  assign win_req = win_dbg_q ? bus.dbg_req : bus.prc_req;
  assign own_req = (state_q == GRANT_DBG) ? bus.dbg_req : bus.prc_req;
  assign oth_req = (state_q == GRANT_DBG) ? bus.prc_req : bus.dbg_req;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    last_prc_d = last_prc_q;
    win_dbg_d  = win_dbg_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      CPU_OWN: begin
        if (bus.prc_req || bus.dbg_req) begin
          win_dbg_d = bus.dbg_req && (!bus.prc_req || last_prc_q);
          req_d     = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A withdrawn request abandons the handover even if the ack never arrives.
        if (!win_req) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end else if (bus.cpu_bus_ack) begin
          state_d = win_dbg_q ? GRANT_DBG : GRANT_PRC;
        end
      end
      GRANT_PRC, GRANT_DBG: begin
        if (!own_req) begin
          cnt_d      = 16'd0;
          last_prc_d = (state_q == GRANT_PRC);
          if (oth_req) begin
            win_dbg_d = (state_q == GRANT_PRC);
            state_d   = GAP;
          end else begin
            req_d   = 1'b0;
            state_d = RELEASE;
          end
        end else begin
          if (cnt_q < TIMEOUT) cnt_d = cnt_q + 16'd1;
          if (cnt_d >= TIMEOUT) err_d = 1'b1;
        end
      end
      GAP:     state_d = win_dbg_q ? GRANT_DBG : GRANT_PRC;
      RELEASE: if (!bus.cpu_bus_ack) state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CPU_OWN;
      req_q      <= 1'b0;
      last_prc_q <= 1'b0;
      win_dbg_q  <= 1'b0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
    end else if (clk_ce) begin
      state_q    <= state_d;
      req_q      <= req_d;
      last_prc_q <= last_prc_d;
      win_dbg_q  <= win_dbg_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.cpu_bus_request = req_q;
  assign bus.prc_grant       = (state_q == GRANT_PRC);
  assign bus.dbg_grant       = (state_q == GRANT_DBG);
  assign bus.timeout_error   = err_q;

  always_comb begin
    bus.address_out = 24'd0;
    bus.data_out    = 8'd0;
    bus.write       = 1'b0;
    bus.read        = 1'b0;
    bus.bus_status  = BUS_COMMAND_IDLE;
    case (state_q)
      CPU_OWN, WAIT_ACK: begin
        bus.address_out = bus.cpu_address_in;
        bus.data_out    = bus.cpu_data_in;
        bus.write       = bus.cpu_write;
        bus.read        = bus.cpu_read;
        bus.bus_status  = bus.cpu_bus_status;
      end
      GRANT_PRC: begin
        bus.address_out = bus.prc_address_in;
        bus.data_out    = bus.prc_data_in;
        bus.write       = bus.prc_write;
        bus.read        = bus.prc_read;
        bus.bus_status  = bus.prc_bus_status;
      end
      GRANT_DBG: begin
        bus.address_out = bus.dbg_address_in;
        bus.data_out    = bus.dbg_data_in;
        bus.write       = bus.dbg_write;
        bus.read        = bus.dbg_read;
        bus.bus_status  = bus.dbg_bus_status;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against an ownership model.
module tb_bus_arbiter;
  localparam logic [1:0] IDLE = 2'b00;
  localparam int         TO   = 8;

  logic clk, reset, clk_ce;
  bus_arbiter_if bif();

  bus_arbiter #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus(bif)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ownership model: who holds the bus (0 CPU, 1 PRC, 2 DBG) plus transitional flags.
  int m_owner = 0, m_winner = 0, m_hold = 0;
  bit m_req = 0, m_waiting = 0, m_gap = 0, m_rel = 0, m_last_prc = 0, m_err = 0;

  always @(posedge clk) begin
    bit pr, dr, ack, xreq, oreq;
    pr = bif.prc_req; dr = bif.dbg_req; ack = bif.cpu_bus_ack;
    if (reset) begin
      m_owner = 0; m_winner = 0; m_hold = 0;
      m_req = 0; m_waiting = 0; m_gap = 0; m_rel = 0; m_last_prc = 0; m_err = 0;
    end else if (clk_ce) begin
      if (m_rel) begin
        if (!ack) m_rel = 0;
      end else if (m_gap) begin
        m_gap = 0;
        m_owner = m_winner;
      end else if (m_owner != 0) begin
        xreq = (m_owner == 1) ? pr : dr;
        oreq = (m_owner == 1) ? dr : pr;
        if (!xreq) begin
          m_hold = 0;
          m_last_prc = (m_owner == 1);
          if (oreq) begin
            m_winner = 3 - m_owner;
            m_gap = 1;
          end else begin
            m_req = 0;
            m_rel = 1;
          end
          m_owner = 0;
        end else begin
          if (m_hold < TO) m_hold++;
          if (m_hold >= TO) m_err = 1;
        end
      end else if (m_waiting) begin
        xreq = (m_winner == 1) ? pr : dr;
        if (!xreq) begin
          m_waiting = 0; m_req = 0; m_rel = 1;
        end else if (ack) begin
          m_waiting = 0; m_owner = m_winner;
        end
      end else if (pr || dr) begin
        m_winner = (dr && (!pr || m_last_prc)) ? 2 : 1;
        m_req = 1;
        m_waiting = 1;
      end
    end
  end

  logic [35:0] eb;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_gap || m_rel) eb = {24'h0, 8'h0, 1'b0, 1'b0, IDLE};
      else if (m_owner == 1)
        eb = {bif.prc_address_in, bif.prc_data_in, bif.prc_write, bif.prc_read, bif.prc_bus_status};
      else if (m_owner == 2)
        eb = {bif.dbg_address_in, bif.dbg_data_in, bif.dbg_write, bif.dbg_read, bif.dbg_bus_status};
      else
        eb = {bif.cpu_address_in, bif.cpu_data_in, bif.cpu_write, bif.cpu_read, bif.cpu_bus_status};
      chk("ctrl", {60'd0, bif.prc_grant, bif.dbg_grant, bif.cpu_bus_request, bif.timeout_error},
          {60'd0, m_owner == 1, m_owner == 2, m_req, m_err});
      chk("bus", {28'd0, bif.address_out, bif.data_out, bif.write, bif.read, bif.bus_status},
          {28'd0, eb});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clk_ce = 1'b1;
    bif.cpu_bus_ack = 0;
    bif.cpu_address_in = 24'hABCDEF; bif.cpu_data_in = 8'h5A;
    bif.cpu_write = 1; bif.cpu_read = 0; bif.cpu_bus_status = 2'b11;
    bif.prc_req = 0; bif.prc_address_in = 24'h001000; bif.prc_data_in = 8'h11;
    bif.prc_write = 0; bif.prc_read = 1; bif.prc_bus_status = 2'b10;
    bif.dbg_req = 0; bif.dbg_address_in = 24'h7F0042; bif.dbg_data_in = 8'hD8;
    bif.dbg_write = 1; bif.dbg_read = 0; bif.dbg_bus_status = 2'b01;
    step(2);
    chk("rst_ctrl", {bif.prc_grant, bif.dbg_grant, bif.cpu_bus_request, bif.timeout_error}, 4'b0000);
    chk("rst_addr", bif.address_out, 24'hABCDEF);
    cmp_en = 1;
    reset = 1'b0;

    // Tie with fresh round-robin state: PRC first, then GAP, then DBG.
    bif.prc_req = 1; bif.dbg_req = 1;
    step(1); chk("tie_req", bif.cpu_bus_request, 1'b1);
    bif.cpu_bus_ack = 1;
    step(1); chk("tie_prc_first", {bif.prc_grant, bif.dbg_grant}, 2'b10);
    chk("tie_prc_addr", bif.address_out, 24'h001000);
    bif.prc_req = 0;
    step(1); chk("gap_grants", {bif.prc_grant, bif.dbg_grant, bif.cpu_bus_request}, 3'b001);
    chk("gap_status", bif.bus_status, IDLE);
    step(1); chk("gap_dbg", {bif.dbg_grant, bif.cpu_bus_request}, 2'b11);
    chk("gap_dbg_addr", bif.address_out, 24'h7F0042);
    bif.dbg_req = 0;
    step(1); chk("rel_after_dbg", {bif.dbg_grant, bif.cpu_bus_request}, 2'b00);
    bif.cpu_bus_ack = 0;
    step(1);

    // Single PRC transaction.
    bif.prc_req = 1;
    step(1); chk("prc_req0", {bif.cpu_bus_request, bif.prc_grant}, 2'b10);
    step(1);
    bif.cpu_bus_ack = 1;
    step(1); chk("prc_grant", bif.prc_grant, 1'b1);
    chk("prc_addr", bif.address_out, 24'h001000);
    bif.prc_req = 0;
    step(1); chk("prc_release", {bif.prc_grant, bif.cpu_bus_request}, 2'b00);
    chk("prc_release_addr", bif.address_out, 24'h000000);
    bif.cpu_bus_ack = 0;
    step(1); chk("prc_cpu_back", bif.address_out, 24'hABCDEF);

    // Round-robin: PRC served last, so DBG wins the tie.
    bif.prc_req = 1; bif.dbg_req = 1;
    step(1);
    bif.cpu_bus_ack = 1;
    step(1); chk("rr_dbg", {bif.prc_grant, bif.dbg_grant}, 2'b01);

    // Reset mid-grant without clk_ce.
    reset = 1; clk_ce = 0; bif.prc_req = 0; bif.dbg_req = 0; bif.cpu_bus_ack = 0;
    step(1); chk("midrst_ctrl", {bif.prc_grant, bif.dbg_grant, bif.cpu_bus_request}, 3'b000);
    chk("midrst_addr", bif.address_out, 24'hABCDEF);
    reset = 0; clk_ce = 1;
    step(1);

    // Withdrawn DBG request.
    bif.dbg_req = 1;
    step(1); chk("wd_req", bif.cpu_bus_request, 1'b1);
    bif.dbg_req = 0;
    step(1); chk("wd_release", {bif.dbg_grant, bif.cpu_bus_request}, 2'b00);
    chk("wd_idle_addr", bif.address_out, 24'h000000);
    step(1); chk("wd_cpu_back", bif.address_out, 24'hABCDEF);

    // Watchdog with TIMEOUT=8.
    bif.prc_req = 1;
    step(1);
    bif.cpu_bus_ack = 1;
    step(1); chk("wdog_start", {bif.prc_grant, bif.timeout_error}, 2'b10);
    step(7); chk("wdog_7", {bif.prc_grant, bif.timeout_error}, 2'b10);
    step(1); chk("wdog_8", {bif.prc_grant, bif.timeout_error}, 2'b11);
    step(12);
    bif.prc_req = 0;
    step(1); chk("wdog_rel", {bif.prc_grant, bif.timeout_error}, 2'b01);
    bif.cpu_bus_ack = 0;
    step(1); chk("wdog_sticky", bif.timeout_error, 1'b1);

    // Randomized traffic with a CPU that acks requests after a random delay.
    for (int i = 0; i < 4000; i++) begin
      step(1);
      clk_ce = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 999) == 0);
      bif.cpu_address_in = 24'($urandom); bif.cpu_data_in = 8'($urandom);
      bif.cpu_write = 1'($urandom); bif.cpu_read = 1'($urandom); bif.cpu_bus_status = 2'($urandom);
      bif.prc_address_in = 24'($urandom); bif.prc_data_in = 8'($urandom);
      bif.prc_write = 1'($urandom); bif.prc_read = 1'($urandom); bif.prc_bus_status = 2'($urandom);
      bif.dbg_address_in = 24'($urandom); bif.dbg_data_in = 8'($urandom);
      bif.dbg_write = 1'($urandom); bif.dbg_read = 1'($urandom); bif.dbg_bus_status = 2'($urandom);
      if (!bif.prc_req) bif.prc_req = ($urandom_range(0, 5) == 0);
      else if ($urandom_range(0, 7) == 0) bif.prc_req = 0;
      if (!bif.dbg_req) bif.dbg_req = ($urandom_range(0, 5) == 0);
      else if ($urandom_range(0, 7) == 0) bif.dbg_req = 0;
      if (bif.cpu_bus_ack != bif.cpu_bus_request && $urandom_range(0, 2) == 0)
        bif.cpu_bus_ack = bif.cpu_bus_request;
    end

    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequences ownership of the shared system bus between the S1C88 CPU (default owner), the PRC, and a debug/save-state master (DBG). It drives the CPU's bus_request, waits for the CPU's bus_ack, then grants one secondary master and muxes its bus signals onto the shared bus. It replaces the ad-hoc bus_ack muxing at the top level and adds fair PRC/DBG sharing plus a hold-time watchdog.

## Interface
Parameters:
- TIMEOUT, 16'd4096, maximum clk_ce cycles a secondary master may hold a grant before timeout_error is set.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clk_ce  in  1  CPU-rate clock enable. All state changes happen only on clk edges with clk_ce=1.
- cpu_bus_ack  in  1  CPU has released the bus.
- cpu_address_in / cpu_data_in / cpu_write / cpu_read / cpu_bus_status  in  24/8/1/1/2  CPU bus signals.
- prc_req / dbg_req  in  1  held high by the master for the whole transaction.
- prc_address_in, prc_data_in, prc_write, prc_read, prc_bus_status  in  24/8/1/1/2  PRC bus signals.
- dbg_address_in, dbg_data_in, dbg_write, dbg_read, dbg_bus_status  in  24/8/1/1/2  DBG bus signals.
- cpu_bus_request  out  1  request to the CPU to release the bus.
- prc_grant / dbg_grant  out  1  registered grants; at most one is high.
- address_out / data_out / write / read / bus_status  out  24/8/1/1/2  shared bus.
- timeout_error  out  1  sticky watchdog flag.

## Operation
- States: CPU_OWN, WAIT_ACK, GRANT_PRC, GRANT_DBG, GAP, RELEASE.
- CPU_OWN: the mux selects the CPU. If prc_req or dbg_req is high, latch the winner and set cpu_bus_request=1, then go to WAIT_ACK.
  - Winner on a tie: PRC, unless the last served secondary was PRC and dbg_req is pending. In that case DBG wins (round-robin bit last_prc).
- WAIT_ACK: the mux still selects the CPU. When cpu_bus_ack=1, go to GRANT_<winner>.
  - If the winner's req dropped before the ack, go straight to RELEASE without granting.
- GRANT_X: X_grant=1 and the mux selects X. A 16-bit hold counter increments each clk_ce. When the counter reaches TIMEOUT, set timeout_error=1 and keep the grant; there is no forced revoke.
- GRANT_X exit on X_req=0: clear the counter and update last_prc.
  - If the other req is high, go to GAP with that master as next owner.
  - Otherwise clear cpu_bus_request and go to RELEASE.
- GAP: lasts one clk_ce cycle. No grant; the bus is idle. Then go to GRANT of the next owner. cpu_bus_request stays high throughout, so the CPU never regains the bus between back-to-back grants.
- RELEASE: the mux drives the bus idle. When cpu_bus_ack=0, go to CPU_OWN.
- Idle bus: address_out=0, data_out=0, write=0, read=0, bus_status=BUS_COMMAND_IDLE.
- Secondary requests in GRANT_X do not preempt X. They are served via GAP.
- timeout_error is cleared only by reset.

## Timing
- Reset values: state=CPU_OWN, cpu_bus_request=0, prc_grant=0, dbg_grant=0, timeout_error=0, last_prc=0, counter=0. The mux selects the CPU, so the outputs equal the CPU inputs.
- Request path: req seen at clk_ce edge N gives cpu_bus_request=1 after edge N.
- Grant latency: cpu_bus_ack seen at clk_ce edge M gives X_grant=1 after edge M.
- Minimum latency: 2 clk_ce cycles from req to grant.
- Release path: req falling seen at edge K gives grant=0 after edge K. The next grant (via GAP) is asserted after edge K+1.
- Mux outputs are combinational from registered state and are valid in the same cycle as the grant.
- Reset asserted mid-grant: on the next clk edge, with or without clk_ce, all outputs return to their reset values and the CPU regains the mux immediately.
- Counter saturates at TIMEOUT; it does not wrap.

## Test plan
- Single PRC transaction: prc_req=1 at edge 0 → cpu_bus_request=1 after edge 0. Assert cpu_bus_ack at edge 2 → prc_grant=1, and address_out equals prc_address_in (e.g. 24'h001000). Drop prc_req → RELEASE, then CPU_OWN once the ack falls.
- PRC/DBG tie: both reqs raised together → PRC is granted first. Drop prc_req → one GAP cycle with bus_status=BUS_COMMAND_IDLE, then dbg_grant=1, with cpu_bus_request held high throughout.
- Round-robin: after PRC is served, tie again → DBG wins.
- Withdrawn request: dbg_req pulses for 1 clk_ce and drops before the ack → no grant; state goes to RELEASE, then CPU_OWN.
- Watchdog: TIMEOUT=8, prc_req held for 20 clk_ce → timeout_error=1 after the 8th grant cycle, grant kept, flag stays set after release.
- Reset mid-grant: reset while dbg_grant=1 → after the next clk edge, all grants=0, cpu_bus_request=0, and address_out equals cpu_address_in.
